// File: rtl/upsample2x_stage.sv
// Nearest-neighbour 2x upsampler: latches a flattened C x H x W map and writes one output element per clock.
// Define UPSAMPLE_CONCAT_EN to append the skip map as extra output channels after the upsampled ones.
module upsample2x_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 2,
  parameter int H          = 2,
  parameter int W          = 2,
  parameter int SKIP_D     = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [D*H*W*DATA_WIDTH-1:0]                   x,
`ifdef UPSAMPLE_CONCAT_EN
  input  logic [SKIP_D*4*H*W*DATA_WIDTH-1:0]            skip,
  output logic [(D+SKIP_D)*4*H*W*DATA_WIDTH-1:0]        out,
`else
  output logic [D*4*H*W*DATA_WIDTH-1:0]                 out,
`endif
  output logic                                          busy,
  output logic                                          done
);

`ifdef UPSAMPLE_CONCAT_EN
  localparam bit CONCAT = 1'b1;
`else
  localparam bit CONCAT = 1'b0;
`endif

  localparam int HO    = 2 * H;
  localparam int WO    = 2 * W;
  localparam int PLANE = HO * WO;
  localparam int CH_N  = D + (CONCAT ? SKIP_D : 0);
  localparam int OUT_N = CH_N * PLANE;
  localparam int CW    = $clog2(CH_N + 1);
  localparam int RW    = $clog2(HO + 1);
  localparam int KW    = $clog2(WO + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  c_q, c_d;
  logic [RW-1:0]                  r_q, r_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [D*H*W*DATA_WIDTH-1:0]    x_q, x_d;
  logic [OUT_N*DATA_WIDTH-1:0]    out_q, out_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
`ifdef UPSAMPLE_CONCAT_EN
  logic [SKIP_D*PLANE*DATA_WIDTH-1:0] skip_q, skip_d;
`endif

  int                             o_idx;
  int                             x_idx;
  logic [DATA_WIDTH-1:0]          src;
  logic                           last_elem;

  // Source/destination addressing from the nested counters; the halving on r/k is the 2x replication.
  always_comb begin
    o_idx = (int'(c_q) * HO + int'(r_q)) * WO + int'(k_q);
    x_idx = (int'(c_q) * H + int'(r_q >> 1)) * W + int'(k_q >> 1);
    src   = '0;
`ifdef UPSAMPLE_CONCAT_EN
    if (int'(c_q) >= D)
      src = skip_q[(o_idx - D * PLANE) * DATA_WIDTH +: DATA_WIDTH];
    else
      src = x_q[x_idx * DATA_WIDTH +: DATA_WIDTH];
`else
    src = x_q[x_idx * DATA_WIDTH +: DATA_WIDTH];
`endif
    last_elem = (c_q == CW'(CH_N - 1)) && (r_q == RW'(HO - 1)) && (k_q == KW'(WO - 1));
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    k_d     = k_q;
    x_d     = x_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UPSAMPLE_CONCAT_EN
    skip_d  = skip_q;
`endif
    case (state_q)
      // A new job waits out the cycle in which done is presented, leaving one quiet IDLE cycle.
      S_IDLE: begin
        if (start && !done_q) begin
          x_d     = x;
`ifdef UPSAMPLE_CONCAT_EN
          skip_d  = skip;
`endif
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        c_d     = '0;
        r_d     = '0;
        k_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        out_d[o_idx * DATA_WIDTH +: DATA_WIDTH] = src;
        if (k_q == KW'(WO - 1)) begin
          k_d = '0;
          if (r_q == RW'(HO - 1)) begin
            r_d = '0;
            c_d = (c_q == CW'(CH_N - 1)) ? '0 : c_q + 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
        if (last_elem)
          state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      x_q     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UPSAMPLE_CONCAT_EN
      skip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      k_q     <= k_d;
      x_q     <= x_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UPSAMPLE_CONCAT_EN
      skip_q  <= skip_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_upsample2x_stage.sv
// Testbench for upsample2x_stage: random and directed jobs checked against an arithmetic reference model.
module tb_upsample2x_stage;
  localparam int DW     = 16;
  localparam int D      = 2;
  localparam int H      = 2;
  localparam int W      = 2;
  localparam int SKIP_D = 2;
  localparam int PLANE  = 4 * H * W;
`ifdef UPSAMPLE_CONCAT_EN
  localparam int CH_N   = D + SKIP_D;
`else
  localparam int CH_N   = D;
`endif
  localparam int OUT_N  = CH_N * PLANE;
  localparam int IN_N   = D * H * W;
  localparam int SK_N   = SKIP_D * PLANE;
  localparam int LIMIT  = OUT_N + 40;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [IN_N*DW-1:0]   x;
  logic [SK_N*DW-1:0]   skip;
  logic [OUT_N*DW-1:0]  out;
  logic                 busy;
  logic                 done;

  int vectors     = 0;
  int miscompares = 0;
  logic [OUT_N*DW-1:0] last_exp;

  upsample2x_stage #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .SKIP_D(SKIP_D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
`ifdef UPSAMPLE_CONCAT_EN
    .skip  (skip),
`endif
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output element i -> (channel, row, col) of the 2H x 2W map, then its source element.
  function automatic logic [OUT_N*DW-1:0] model(input logic [IN_N*DW-1:0] xv,
                                                input logic [SK_N*DW-1:0] sv);
    logic [OUT_N*DW-1:0] m;
    int c, rem, r, k;
    m = '0;
    for (int i = 0; i < OUT_N; i++) begin
      c   = i / PLANE;
      rem = i % PLANE;
      r   = rem / (2 * W);
      k   = rem % (2 * W);
      if (c < D) m[i*DW +: DW] = xv[(c*H*W + (r/2)*W + k/2)*DW +: DW];
      else       m[i*DW +: DW] = sv[((c-D)*PLANE + rem)*DW +: DW];
    end
    return m;
  endfunction

  function automatic logic [OUT_N*DW-1:0] merge(input logic [OUT_N*DW-1:0] old_v,
                                                input logic [OUT_N*DW-1:0] new_v,
                                                input int n);
    logic [OUT_N*DW-1:0] m;
    m = old_v;
    for (int i = 0; i < n; i++) m[i*DW +: DW] = new_v[i*DW +: DW];
    return m;
  endfunction

  function automatic logic [IN_N*DW-1:0] rand_x();
    logic [IN_N*DW-1:0] v;
    for (int i = 0; i < IN_N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [SK_N*DW-1:0] rand_skip();
    logic [SK_N*DW-1:0] v;
    for (int i = 0; i < SK_N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge just after the start-sampling edge E0.
  task automatic launch(input logic [IN_N*DW-1:0] xv, input logic [SK_N*DW-1:0] sv);
    @(negedge clk);
    x = xv; skip = sv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (lat < LIMIT && done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int dn;
    reset = 1'b1; start = 1'b0; x = '0; skip = '0;
    repeat (3) @(negedge clk);
    vectors++; if (out !== '0) begin miscompares++; $display("FAIL reset_out: got %h expected 0", out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    x = rand_x(); start = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_busy: got %b expected 0", busy); end
    reset = 1'b0; start = 1'b0;
    dn = 0;
    for (int i = 0; i < OUT_N + 6; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    vectors++; if (dn != 0) begin miscompares++; $display("FAIL reset_start_ignored: activity %0d expected 0", dn); end
    vectors++; if (out !== '0) begin miscompares++; $display("FAIL reset_start_out: got %h expected 0", out); end
    last_exp = '0;
  endtask

  task automatic test_fixed();
    logic [IN_N*DW-1:0]  xv;
    logic [SK_N*DW-1:0]  sv;
    logic [OUT_N*DW-1:0] exp_v;
    logic [4*DW-1:0]     row_v;
    int lat, bn;
    xv = {16'hC400, 16'hC200, 16'hC000, 16'hBC00, 16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    for (int i = 0; i < SK_N; i++) sv[i*DW +: DW] = 16'(16'h0100 + i);
    exp_v = model(xv, sv);
    launch(xv, sv);
    wait_done(lat, bn);
    vectors++; if (lat != OUT_N + 2) begin miscompares++; $display("FAIL fixed_done_latency: got %0d expected %0d", lat, OUT_N + 2); end
    vectors++; if (bn != OUT_N + 2) begin miscompares++; $display("FAIL fixed_busy_cycles: got %0d expected %0d", bn, OUT_N + 2); end
    vectors++; if (out !== exp_v) begin miscompares++; $display("FAIL fixed_out: got %h expected %h", out, exp_v); end
    row_v = {16'hC400, 16'hC400, 16'hC200, 16'hC200};
    vectors++; if (out[28*DW +: 4*DW] !== row_v) begin miscompares++; $display("FAIL fixed_ch1_row3: got %h expected %h", out[28*DW +: 4*DW], row_v); end
    row_v = {16'h4000, 16'h4000, 16'h3C00, 16'h3C00};
    vectors++; if (out[0 +: 4*DW] !== row_v) begin miscompares++; $display("FAIL fixed_ch0_row0: got %h expected %h", out[0 +: 4*DW], row_v); end
`ifdef UPSAMPLE_CONCAT_EN
    vectors++; if (out[D*PLANE*DW +: SK_N*DW] !== sv) begin miscompares++; $display("FAIL fixed_skip: got %h expected %h", out[D*PLANE*DW +: SK_N*DW], sv); end
`endif
    step();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL fixed_done_width: got %b expected 0", done); end
    x = rand_x();
    repeat (4) step();
    vectors++; if (out !== exp_v || busy !== 1'b0) begin miscompares++; $display("FAIL fixed_hold: got %h busy %b expected %h busy 0", out, busy, exp_v); end
    last_exp = exp_v;
  endtask

  task automatic test_random();
    logic [IN_N*DW-1:0]  xv;
    logic [SK_N*DW-1:0]  sv;
    logic [OUT_N*DW-1:0] exp_v, part_v;
    int lat, bn, bpre;
    for (int t = 0; t < 4; t++) begin
      xv = rand_x(); sv = rand_skip();
      exp_v = model(xv, sv);
      launch(xv, sv);
      x = rand_x(); skip = rand_skip();
      bpre = 0;
      for (int i = 0; i < 8; i++) begin
        if (busy === 1'b1) bpre++;
        step();
      end
      part_v = merge(last_exp, exp_v, 7);
      vectors++; if (out !== part_v) begin miscompares++; $display("FAIL random_partial[%0d]: got %h expected %h", t, out, part_v); end
      wait_done(lat, bn);
      vectors++; if (lat + 8 != OUT_N + 2 || bn + bpre != OUT_N + 2) begin miscompares++; $display("FAIL random_timing[%0d]: latency %0d busy %0d expected %0d", t, lat + 8, bn + bpre, OUT_N + 2); end
      vectors++; if (out !== exp_v) begin miscompares++; $display("FAIL random_out[%0d]: got %h expected %h", t, out, exp_v); end
      last_exp = exp_v;
    end
  endtask

  task automatic test_mid_reset();
    int dn;
    launch(rand_x(), rand_skip());
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (out !== '0) begin miscompares++; $display("FAIL midreset_out: got %h expected 0", out); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_ctrl: busy %b done %b expected 0 0", busy, done); end
    dn = 0;
    for (int i = 0; i < OUT_N + 6; i++) begin
      step();
      if (done === 1'b1) dn++;
    end
    vectors++; if (dn != 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dn); end
    last_exp = '0;
  endtask

  task automatic test_ignored_start();
    logic [IN_N*DW-1:0]  xv;
    logic [SK_N*DW-1:0]  sv;
    logic [OUT_N*DW-1:0] exp_v;
    int lat, bn, act;
    xv = rand_x(); sv = rand_skip();
    exp_v = model(xv, sv);
    launch(xv, sv);
    repeat (5) step();
    x = rand_x(); skip = rand_skip(); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, bn);
    vectors++; if (lat + 6 != OUT_N + 2) begin miscompares++; $display("FAIL ignored_latency: got %0d expected %0d", lat + 6, OUT_N + 2); end
    vectors++; if (out !== exp_v) begin miscompares++; $display("FAIL ignored_out: got %h expected %h", out, exp_v); end
    act = 0;
    for (int i = 0; i < OUT_N + 6; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) act++;
    end
    vectors++; if (act != 0) begin miscompares++; $display("FAIL ignored_not_queued: activity %0d expected 0", act); end
    last_exp = exp_v;
  endtask

  task automatic test_back_to_back();
    logic [IN_N*DW-1:0]  x1, x2;
    logic [SK_N*DW-1:0]  s1, s2;
    int lat, bn, n;
    x1 = rand_x(); s1 = rand_skip(); x2 = rand_x(); s2 = rand_skip();
    @(negedge clk);
    x = x1; skip = s1; start = 1'b1;
    step();
    x = x2; skip = s2;
    wait_done(lat, bn);
    vectors++; if (lat != OUT_N + 2) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, OUT_N + 2); end
    vectors++; if (out !== model(x1, s1)) begin miscompares++; $display("FAIL b2b_first_out: got %h expected %h", out, model(x1, s1)); end
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < LIMIT);
    start = 1'b0;
    vectors++; if (n != OUT_N + 4) begin miscompares++; $display("FAIL b2b_done_spacing: got %0d expected %0d", n, OUT_N + 4); end
    vectors++; if (out !== model(x2, s2)) begin miscompares++; $display("FAIL b2b_second_out: got %h expected %h", out, model(x2, s2)); end
    repeat (3) step();
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL b2b_stop: busy %b done %b expected 0 0", busy, done); end
    last_exp = model(x2, s2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x = '0; skip = '0; last_exp = '0;
    test_reset();
    test_fixed();
    test_random();
    test_mid_reset();
    test_ignored_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
